// File: rtl/stopwatch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | stopwatch_pkg : shared state encodings and timing constants           |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
package stopwatch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_PAUSE = 2'b10,
      ST_LAP   = 2'b11
   } state_t;

   // 10 ms debounce and 100 Hz tick at 50 MHz
   localparam int C_DEB_CYCLES_DEF = 500000;
   localparam int C_TICK_DIV_DEF   = 500000;

   // Short values so simulation reaches every state in a few hundred cycles
   localparam int C_SIM_DEB_CYCLES = 4;
   localparam int C_SIM_TICK_DIV   = 10;

endpackage
`default_nettype wire

// File: rtl/stopwatch_ctrl_key_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | key_debounce : 2-flop synchronizer, stable-count debounce, press pulse |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
module key_debounce
   import stopwatch_pkg::*;
#(
   parameter int DEB_CYCLES = C_DEB_CYCLES_DEF
) (
   input  logic clock,
   input  logic reset,
   input  logic i_key,
   output logic o_press
);

   localparam int              CW        = $clog2(DEB_CYCLES);
   localparam logic [CW-1:0]   C_CNT_MAX = CW'(DEB_CYCLES - 1);

   logic          r_s1;
   logic          r_s2;
   logic          r_deb;
   logic          r_deb_d;
   logic [CW-1:0] r_cnt;

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_s1    <= 1'b1;
         r_s2    <= 1'b1;
         r_deb   <= 1'b1;
         r_deb_d <= 1'b1;
         r_cnt   <= '0;
      end else begin
         r_s1    <= i_key;
         r_s2    <= r_s1;
         r_deb_d <= r_deb;
         // Any sample that agrees with the accepted level restarts the count
         if (r_s2 == r_deb) begin
            r_cnt <= '0;
         end else if (r_cnt == C_CNT_MAX) begin
            r_deb <= r_s2;
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   // Falling edge of the active-low debounced level only; release is silent
   assign o_press = r_deb_d & ~r_deb;

endmodule
`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | stopwatch_ctrl : key debounce, IDLE/RUN/PAUSE/LAP FSM, 100 Hz tick    |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int DEB_CYCLES = C_DEB_CYCLES_DEF,
   parameter int TICK_DIV   = C_TICK_DIV_DEF
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       key_ss,
   input  logic       key_lap,
   output logic       tick_en,
   output logic       clr,
   output logic       hold,
   output logic [1:0] state
);

   localparam int            PW          = $clog2(TICK_DIV);
   localparam logic [PW-1:0] C_PRESC_MAX = PW'(TICK_DIV - 1);

   logic          w_ss;
   logic          w_lap;
   state_t        r_state;
   state_t        w_state_nx;
   logic [PW-1:0] r_presc;
   logic [PW-1:0] w_presc_nx;
   logic          r_tick;
   logic          w_tick_nx;
   logic          r_clr;
   logic          w_clr_nx;
   logic          r_hold;
   logic          w_hold_nx;

   key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_ss (
      .clock   (clock),
      .reset   (reset),
      .i_key   (key_ss),
      .o_press (w_ss)
   );

   key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_lap (
      .clock   (clock),
      .reset   (reset),
      .i_key   (key_lap),
      .o_press (w_lap)
   );

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_state <= ST_IDLE;
         r_presc <= '0;
         r_tick  <= 1'b0;
         r_clr   <= 1'b0;
         r_hold  <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_presc <= w_presc_nx;
         r_tick  <= w_tick_nx;
         r_clr   <= w_clr_nx;
         r_hold  <= w_hold_nx;
      end
   end

   always_comb begin
      w_state_nx = r_state;
      w_clr_nx   = 1'b0;
      w_presc_nx = r_presc;
      w_tick_nx  = 1'b0;

      // Start/stop is tested first, so it wins over a same-cycle lap press
      unique case (r_state)
         ST_IDLE:  if (w_ss) w_state_nx = ST_RUN;
         ST_RUN:   if (w_ss) w_state_nx = ST_PAUSE;
                   else if (w_lap) w_state_nx = ST_LAP;
         ST_LAP:   if (w_ss) w_state_nx = ST_PAUSE;
                   else if (w_lap) w_state_nx = ST_RUN;
         ST_PAUSE: if (w_ss) w_state_nx = ST_RUN;
                   else if (w_lap) begin
                      w_state_nx = ST_IDLE;
                      w_clr_nx   = 1'b1;
                   end
         default:  w_state_nx = ST_IDLE;
      endcase

      w_hold_nx = (w_state_nx == ST_LAP);

      // Prescaler follows the pre-edge state; PAUSE freezes it so resume loses no time
      unique case (r_state)
         ST_RUN, ST_LAP: begin
            if (r_presc == C_PRESC_MAX) begin
               w_presc_nx = '0;
               w_tick_nx  = 1'b1;
            end else begin
               w_presc_nx = r_presc + 1'b1;
            end
         end
         ST_PAUSE: w_presc_nx = r_presc;
         default:  w_presc_nx = '0;
      endcase
   end

   assign tick_en = r_tick;
   assign clr     = r_clr;
   assign hold    = r_hold;
   assign state   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_stopwatch_ctrl : directed self-checking bench for stopwatch_ctrl   |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_stopwatch_ctrl;
   import stopwatch_pkg::*;

   logic       clock   = 1'b0;
   logic       reset   = 1'b0;
   logic       key_ss  = 1'b1;
   logic       key_lap = 1'b1;
   logic       tick_en;
   logic       clr;
   logic       hold;
   logic [1:0] state;

   int total     = 0;
   int bad       = 0;
   int cyc       = 0;
   int tick_cnt  = 0;
   int clr_cnt   = 0;
   int hold_bad  = 0;
   int coinc_bad = 0;
   int last_tick = -1;
   int tick_q[$];
   bit mon_en    = 1'b0;

   stopwatch_ctrl #(
      .DEB_CYCLES (C_SIM_DEB_CYCLES),
      .TICK_DIV   (C_SIM_TICK_DIV)
   ) dut (
      .clock   (clock),
      .reset   (reset),
      .key_ss  (key_ss),
      .key_lap (key_lap),
      .tick_en (tick_en),
      .clr     (clr),
      .hold    (hold),
      .state   (state)
   );

   always #5 clock = ~clock;

   // Edge k is numbered k; outputs after edge k are logged against k
   always @(posedge clock) begin
      cyc = cyc + 1;
      #2;
      if (mon_en) begin
         if (tick_en === 1'b1) begin
            tick_cnt++;
            last_tick = cyc;
            tick_q.push_back(cyc);
         end
         if (clr === 1'b1) clr_cnt++;
         if (hold !== (state == 2'b11)) hold_bad++;
         if (clr === 1'b1 && tick_en === 1'b1) coinc_bad++;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   task automatic to_cyc(input int c);
      while (cyc < c) @(negedge clock);
   endtask

   // Called at a negedge; key is first sampled low at edge e0, returns at negedge e0+len-1
   task automatic press(input bit ss, input bit lp, input int len, output int e0);
      if (ss) key_ss = 1'b0;
      if (lp) key_lap = 1'b0;
      e0 = cyc + 1;
      repeat (len) @(negedge clock);
      key_ss  = 1'b1;
      key_lap = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(negedge clock);
      total++; if (state !== 2'b00) begin bad++; $display("FAIL reset_state: got %0d want 0", state); end
      total++; if ({tick_en, clr, hold} !== 3'b000) begin bad++; $display("FAIL reset_outs: got %b want 000", {tick_en, clr, hold}); end
      reset  = 1'b1;
      mon_en = 1'b1;
      repeat (50) @(negedge clock);
      total++; if (state !== 2'b00) begin bad++; $display("FAIL idle_state: got %0d want 0", state); end
      total++; if (tick_cnt != 0 || clr_cnt != 0 || hold_bad != 0) begin
         bad++; $display("FAIL idle_quiet: got ticks=%0d clrs=%0d holdbad=%0d want 0/0/0", tick_cnt, clr_cnt, hold_bad);
      end
   endtask

   task automatic test_glitch();
      key_ss = 1'b0;
      repeat (3) @(negedge clock);
      key_ss = 1'b1;
      repeat (20) @(negedge clock);
      total++; if (state !== 2'b00 || tick_cnt != 0) begin
         bad++; $display("FAIL glitch: got state=%0d ticks=%0d want 0/0", state, tick_cnt);
      end
   endtask

   task automatic test_start();
      int e0;
      tick_q.delete();
      key_ss = 1'b0;
      e0 = cyc + 1;
      to_cyc(e0 + 5);
      total++; if (state !== 2'b00) begin bad++; $display("FAIL start_early: got %0d want 0", state); end
      to_cyc(e0 + 6);
      total++; if (state !== 2'b01) begin bad++; $display("FAIL start_run: got %0d want 1", state); end
      to_cyc(e0 + 9);
      key_ss = 1'b1;
      to_cyc(e0 + 37);
      total++; if (tick_q.size() < 3 || tick_q[0] != e0 + 16 || tick_q[1] != e0 + 26 || tick_q[2] != e0 + 36) begin
         bad++; $display("FAIL start_ticks: got n=%0d first=%0d want n>=3 first=%0d period 10",
                         tick_q.size(), (tick_q.size() > 0) ? tick_q[0] - e0 : -1, 16);
      end
   endtask

   task automatic test_lap();
      int e0;
      int tprev;
      bit ok;
      repeat (10) @(negedge clock);
      tprev = last_tick;
      tick_q.delete();
      press(1'b0, 1'b1, 6, e0);
      total++; if (state !== 2'b01) begin bad++; $display("FAIL lap_early: got %0d want 1", state); end
      @(negedge clock);
      total++; if (state !== 2'b11 || hold !== 1'b1) begin
         bad++; $display("FAIL lap_enter: got state=%0d hold=%b want 3/1", state, hold);
      end
      repeat (10) @(negedge clock);
      press(1'b0, 1'b1, 6, e0);
      @(negedge clock);
      total++; if (state !== 2'b01 || hold !== 1'b0) begin
         bad++; $display("FAIL lap_exit: got state=%0d hold=%b want 1/0", state, hold);
      end
      repeat (20) @(negedge clock);
      ok = (tick_q.size() >= 4) && (((tick_q[0] - tprev) % 10) == 0);
      for (int i = 1; i < tick_q.size(); i++) if (tick_q[i] - tick_q[i-1] != 10) ok = 1'b0;
      total++; if (!ok) begin bad++; $display("FAIL lap_period: got n=%0d want evenly spaced period 10", tick_q.size()); end
      total++; if (hold_bad != 0) begin bad++; $display("FAIL hold_track: got %0d want 0", hold_bad); end
   endtask

   task automatic test_pause_resume();
      int d;
      int e0;
      int e1;
      int er;
      int n0;
      d = last_tick + 9;
      while (d < cyc) d += 10;
      to_cyc(d);
      press(1'b1, 1'b0, 6, e0);
      total++; if (last_tick != e0) begin bad++; $display("FAIL pause_align: got %0d want %0d", last_tick, e0); end
      @(negedge clock);
      total++; if (state !== 2'b10) begin bad++; $display("FAIL pause_enter: got %0d want 2", state); end
      n0 = tick_cnt;
      repeat (20) @(negedge clock);
      total++; if (tick_cnt != n0 || state !== 2'b10) begin
         bad++; $display("FAIL pause_quiet: got ticks=%0d state=%0d want %0d/2", tick_cnt, state, n0);
      end
      press(1'b1, 1'b0, 6, e1);
      @(negedge clock);
      er = e1 + 6;
      total++; if (state !== 2'b01) begin bad++; $display("FAIL resume_run: got %0d want 1", state); end
      to_cyc(er + 3);
      total++; if (tick_cnt != n0) begin bad++; $display("FAIL resume_early: got %0d want %0d", tick_cnt, n0); end
      to_cyc(er + 4);
      total++; if (last_tick != er + 4 || tick_en !== 1'b1) begin
         bad++; $display("FAIL resume_tick: got %0d want %0d", last_tick - er, 4);
      end
   endtask

   task automatic test_clear();
      int e0;
      int c0;
      repeat (10) @(negedge clock);
      press(1'b1, 1'b0, 6, e0);
      @(negedge clock);
      total++; if (state !== 2'b10) begin bad++; $display("FAIL clear_pause: got %0d want 2", state); end
      repeat (10) @(negedge clock);
      c0 = clr_cnt;
      press(1'b0, 1'b1, 6, e0);
      total++; if (clr !== 1'b0 || state !== 2'b10) begin
         bad++; $display("FAIL clear_early: got clr=%b state=%0d want 0/2", clr, state);
      end
      @(negedge clock);
      total++; if (state !== 2'b00 || clr !== 1'b1 || tick_en !== 1'b0) begin
         bad++; $display("FAIL clear_pulse: got state=%0d clr=%b tick=%b want 0/1/0", state, clr, tick_en);
      end
      @(negedge clock);
      total++; if (clr !== 1'b0) begin bad++; $display("FAIL clear_width: got %b want 0", clr); end
      repeat (5) @(negedge clock);
      total++; if (clr_cnt != c0 + 1 || coinc_bad != 0) begin
         bad++; $display("FAIL clear_count: got %0d coinc=%0d want %0d/0", clr_cnt - c0, coinc_bad, 1);
      end
   endtask

   task automatic test_back_to_back();
      int e0;
      repeat (10) @(negedge clock);
      press(1'b1, 1'b0, 6, e0);
      @(negedge clock);
      total++; if (state !== 2'b01) begin bad++; $display("FAIL prio_run: got %0d want 1", state); end
      repeat (10) @(negedge clock);
      press(1'b1, 1'b1, 6, e0);
      @(negedge clock);
      total++; if (state !== 2'b10) begin bad++; $display("FAIL prio_both: got %0d want 2", state); end
      repeat (20) @(negedge clock);
      total++; if (state !== 2'b10 || hold !== 1'b0) begin
         bad++; $display("FAIL prio_settle: got state=%0d hold=%b want 2/0", state, hold);
      end
   endtask

   task automatic test_reset_lap();
      int e0;
      int c0;
      repeat (10) @(negedge clock);
      press(1'b1, 1'b0, 6, e0);
      repeat (11) @(negedge clock);
      press(1'b0, 1'b1, 6, e0);
      @(negedge clock);
      total++; if (state !== 2'b11) begin bad++; $display("FAIL rlap_enter: got %0d want 3", state); end
      repeat (3) @(negedge clock);
      c0 = clr_cnt;
      reset = 1'b0;
      @(negedge clock);
      total++; if (state !== 2'b00 || hold !== 1'b0 || clr !== 1'b0 || tick_en !== 1'b0) begin
         bad++; $display("FAIL rlap_reset: got state=%0d hold=%b clr=%b tick=%b want 0/0/0/0", state, hold, clr, tick_en);
      end
      reset = 1'b1;
      repeat (5) @(negedge clock);
      total++; if (clr_cnt != c0 || state !== 2'b00) begin
         bad++; $display("FAIL rlap_after: got clrs=%0d state=%0d want 0/0", clr_cnt - c0, state);
      end
   endtask

   initial begin
      test_reset();
      test_glitch();
      test_start();
      test_lap();
      test_pause_resume();
      test_clear();
      test_back_to_back();
      test_reset_lap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
